// File: rtl/mem_rsp_compare_if.sv
// Beat streams and status outputs of the multi-channel response checker.
// Per-channel fields are packed flat, channel 0 in the least significant slice.
interface mem_rsp_compare_if #(
   parameter int NumChan   = 6,
   parameter int DataWidth = 64,
   parameter int CntWidth  = 16
) ();
   localparam int MaskW = DataWidth / 8;
   localparam int TotW  = CntWidth + $clog2(NumChan + 1);

   logic [NumChan-1:0]           ref_valid;
   logic [NumChan-1:0]           ref_ready;
   logic [NumChan*DataWidth-1:0] ref_data;
   logic [NumChan*MaskW-1:0]     ref_mask;
   logic [NumChan-1:0]           dut_valid;
   logic [NumChan-1:0]           dut_ready;
   logic [NumChan*DataWidth-1:0] dut_data;
   logic [NumChan-1:0]           mismatch;
   logic [NumChan*CntWidth-1:0]  err_cnt;
   logic [TotW-1:0]              total_err;
   logic [NumChan-1:0]           timeout;
   logic [NumChan-1:0]           busy;

   modport master (
      output ref_valid, ref_data, ref_mask, dut_valid, dut_data,
      input  ref_ready, dut_ready, mismatch, err_cnt, total_err, timeout, busy
   );

   modport slave (
      input  ref_valid, ref_data, ref_mask, dut_valid, dut_data,
      output ref_ready, dut_ready, mismatch, err_cnt, total_err, timeout, busy
   );
endinterface

// File: rtl/mem_rsp_compare.sv
// Latency-tolerant per-channel comparator: buffers reference and DUT beats,
// pops them in pairs, and reports masked miscompares, error counts and timeouts.
module mem_rsp_compare #(
   parameter int NumChan       = 6,
   parameter int DataWidth     = 64,
   parameter int FifoDepth     = 8,
   parameter int CntWidth      = 16,
   parameter int TimeoutCycles = 1024
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   mem_rsp_compare_if.slave bus
);
   localparam int MaskW = DataWidth / 8;
   localparam int PtrW  = $clog2(FifoDepth);
   localparam int OccW  = $clog2(FifoDepth + 1);
   localparam int WaitW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
   localparam int TotW  = CntWidth + $clog2(NumChan + 1);

   localparam logic [OccW-1:0]  OccFull   = OccW'(FifoDepth);
   localparam logic [PtrW-1:0]  PtrLast   = PtrW'(FifoDepth - 1);
   localparam logic [WaitW-1:0] WaitLimit = WaitW'(TimeoutCycles);

   logic [NumChan-1:0]  ref_ready_w;
   logic [NumChan-1:0]  dut_ready_w;
   logic [NumChan-1:0]  mismatch_w;
   logic [NumChan-1:0]  timeout_w;
   logic [NumChan-1:0]  busy_w;
   logic [CntWidth-1:0] err_cnt_w [NumChan];

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrLast) ? '0 : p + 1'b1;
   endfunction

   // Handshake: a beat transfers on valid & ready at the rising edge. ready is
   // derived only from registered occupancy, clear_i and rst_ni, never from valid.
   for (genvar ch = 0; ch < NumChan; ch++) begin : g_chan
      logic [DataWidth-1:0] ref_mem  [FifoDepth];
      logic [MaskW-1:0]     mask_mem [FifoDepth];
      logic [DataWidth-1:0] dut_mem  [FifoDepth];

      logic [PtrW-1:0] ref_wp, ref_rp, dut_wp, dut_rp;
      logic [OccW-1:0] ref_occ, dut_occ;

      logic [DataWidth-1:0] ref_in, dut_in;
      logic [MaskW-1:0]     mask_in;
      logic                 ref_ready, dut_ready;
      logic                 ref_push, dut_push;
      logic                 ref_nonempty, dut_nonempty;
      logic                 pop;

      logic [DataWidth-1:0] byte_mask;
      logic                 miscompare;
      logic                 one_sided;

      logic                 mismatch_q;
      logic [CntWidth-1:0]  err_q;
      logic [WaitW-1:0]     wait_q;
      logic [WaitW-1:0]     wait_next;
      logic                 timeout_q;

      assign ref_in  = bus.ref_data[ch*DataWidth +: DataWidth];
      assign dut_in  = bus.dut_data[ch*DataWidth +: DataWidth];
      assign mask_in = bus.ref_mask[ch*MaskW +: MaskW];

      assign ref_nonempty = (ref_occ != '0);
      assign dut_nonempty = (dut_occ != '0);
      assign ref_ready    = rst_ni & ~clear_i & (ref_occ != OccFull);
      assign dut_ready    = rst_ni & ~clear_i & (dut_occ != OccFull);
      assign ref_push     = bus.ref_valid[ch] & ref_ready;
      assign dut_push     = bus.dut_valid[ch] & dut_ready;
      assign pop          = ref_nonempty & dut_nonempty & ~clear_i;
      assign one_sided    = ref_nonempty ^ dut_nonempty;

      // Storage carries no reset; occupancy alone decides what is valid.
      always_ff @(posedge clk_i) begin
         if (ref_push) begin
            ref_mem[ref_wp]  <= ref_in;
            mask_mem[ref_wp] <= mask_in;
         end
         if (dut_push) begin
            dut_mem[dut_wp] <= dut_in;
         end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            ref_wp  <= '0;
            ref_rp  <= '0;
            ref_occ <= '0;
         end else if (clear_i) begin
            ref_wp  <= '0;
            ref_rp  <= '0;
            ref_occ <= '0;
         end else begin
            if (ref_push) ref_wp <= ptr_inc(ref_wp);
            if (pop)      ref_rp <= ptr_inc(ref_rp);
            case ({ref_push, pop})
               2'b10:   ref_occ <= ref_occ + 1'b1;
               2'b01:   ref_occ <= ref_occ - 1'b1;
               default: ref_occ <= ref_occ;
            endcase
         end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            dut_wp  <= '0;
            dut_rp  <= '0;
            dut_occ <= '0;
         end else if (clear_i) begin
            dut_wp  <= '0;
            dut_rp  <= '0;
            dut_occ <= '0;
         end else begin
            if (dut_push) dut_wp <= ptr_inc(dut_wp);
            if (pop)      dut_rp <= ptr_inc(dut_rp);
            case ({dut_push, pop})
               2'b10:   dut_occ <= dut_occ + 1'b1;
               2'b01:   dut_occ <= dut_occ - 1'b1;
               default: dut_occ <= dut_occ;
            endcase
         end
      end

      always_comb begin
         byte_mask = '0;
         for (int b = 0; b < MaskW; b++) begin
            byte_mask[b*8 +: 8] = {8{mask_mem[ref_rp][b]}};
         end
         miscompare = |((ref_mem[ref_rp] ^ dut_mem[dut_rp]) & byte_mask);
      end

      // The pulse and the counter step on the same edge that pops the pair.
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            mismatch_q <= 1'b0;
            err_q      <= '0;
         end else if (clear_i) begin
            mismatch_q <= 1'b0;
            err_q      <= '0;
         end else begin
            mismatch_q <= pop & miscompare;
            if (pop && miscompare && (err_q != {CntWidth{1'b1}})) begin
               err_q <= err_q + 1'b1;
            end
         end
      end

      assign wait_next = wait_q + 1'b1;

      // The flag rises on the edge where the wait count reaches the limit.
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            wait_q    <= '0;
            timeout_q <= 1'b0;
         end else if (clear_i || (TimeoutCycles == 0)) begin
            wait_q    <= '0;
            timeout_q <= 1'b0;
         end else if (one_sided) begin
            if (wait_q != WaitLimit) begin
               wait_q <= wait_next;
               if (wait_next == WaitLimit) timeout_q <= 1'b1;
            end
         end else begin
            wait_q <= '0;
         end
      end

      assign ref_ready_w[ch] = ref_ready;
      assign dut_ready_w[ch] = dut_ready;
      assign mismatch_w[ch]  = mismatch_q;
      assign timeout_w[ch]   = timeout_q;
      assign busy_w[ch]      = ref_nonempty | dut_nonempty;
      assign err_cnt_w[ch]   = err_q;
   end

   logic [NumChan*CntWidth-1:0] err_flat;
   logic [TotW-1:0]             total_sum;

   always_comb begin
      err_flat  = '0;
      total_sum = '0;
      for (int i = 0; i < NumChan; i++) begin
         err_flat[i*CntWidth +: CntWidth] = err_cnt_w[i];
         total_sum = total_sum + TotW'(err_cnt_w[i]);
      end
   end

   assign bus.ref_ready = ref_ready_w;
   assign bus.dut_ready = dut_ready_w;
   assign bus.mismatch  = mismatch_w;
   assign bus.timeout   = timeout_w;
   assign bus.busy      = busy_w;
   assign bus.err_cnt   = err_flat;
   assign bus.total_err = total_sum;
endmodule

// File: tb/tb_mem_rsp_compare.sv
// Directed bench for mem_rsp_compare: table of masked compares plus hand-written
// sequences for backpressure, timeout, saturation, clear and mid-burst reset.
module tb_mem_rsp_compare;
   localparam int NCh  = 6;
   localparam int DW   = 64;
   localparam int CW   = 4;
   localparam int TOut = 16;
   localparam int TW   = CW + $clog2(NCh + 1);

   logic clk_i;
   logic rst_ni;
   logic clear_i;

   int tests;
   int fails;

   logic [0:0] exp_q[$];

   mem_rsp_compare_if #(.NumChan(NCh), .DataWidth(DW), .CntWidth(CW)) bus ();

   mem_rsp_compare #(
      .NumChan(NCh), .DataWidth(DW), .FifoDepth(8), .CntWidth(CW), .TimeoutCycles(TOut)
   ) dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clear_i(clear_i),
      .bus    (bus)
   );

   // clock / watchdog
   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [63:0] ref_d;
      logic [63:0] dut_d;
      logic [7:0]  mask;
      logic        exp_mis;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [CW-1:0] cnt_of(input int ch);
      return bus.err_cnt[ch*CW +: CW];
   endfunction

   task automatic idle();
      bus.ref_valid = '0;
      bus.dut_valid = '0;
   endtask

   // One beat on the selected sides; returns 1 ns after the push edge.
   task automatic push(input int ch, input bit do_ref, input bit do_dut,
                       input logic [63:0] r, input logic [63:0] d, input logic [7:0] m);
      @(posedge clk_i);
      #1;
      bus.ref_data[ch*DW +: DW] = r;
      bus.dut_data[ch*DW +: DW] = d;
      bus.ref_mask[ch*8 +: 8]   = m;
      bus.ref_valid[ch]         = do_ref;
      bus.dut_valid[ch]         = do_dut;
      @(posedge clk_i);
      #1;
      idle();
   endtask

   // After a paired push: check the pulse one cycle after the pop, then its fall.
   task automatic check_pair(input int ch, input logic exp_mis, input string name);
      @(negedge clk_i);
      chk({name, "_busy_before_pop"}, 64'(bus.busy[ch]), 64'd1);
      @(negedge clk_i);
      chk({name, "_mismatch"}, 64'(bus.mismatch[ch]), 64'(exp_mis));
      chk({name, "_busy_after_pop"}, 64'(bus.busy[ch]), 64'd0);
      @(negedge clk_i);
      chk({name, "_pulse_width"}, 64'(bus.mismatch[ch]), 64'd0);
   endtask

   logic [CW-1:0] exp_cnt3;
   logic [TW-1:0] exp_total;

   initial begin
      tests    = 0;
      fails    = 0;
      rst_ni   = 1'b0;
      clear_i  = 1'b0;
      bus.ref_valid = '0;
      bus.dut_valid = '0;
      bus.ref_data  = '0;
      bus.dut_data  = '0;
      bus.ref_mask  = '0;

      vecs[0] = '{64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 8'h00, 1'b0};
      vecs[1] = '{64'hDEADBEEFCAFEF00D, 64'hDEADBEEFCAFEF00D, 8'hFF, 1'b0};
      vecs[2] = '{64'hDEADBEEFCAFEF00D, 64'hDEADBEEFCAFEF00C, 8'hFF, 1'b1};
      vecs[3] = '{64'h0000000000000000, 64'h0000005A00000000, 8'h0F, 1'b0};
      vecs[4] = '{64'h0000000000000000, 64'h0000005A00000000, 8'h10, 1'b1};
      vecs[5] = '{64'h7FFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 8'h80, 1'b1};

      // reset
      repeat (2) @(posedge clk_i);
      #1;
      chk("reset_ref_ready", 64'(bus.ref_ready), 64'd0);
      chk("reset_dut_ready", 64'(bus.dut_ready), 64'd0);
      chk("reset_busy", 64'(bus.busy), 64'd0);
      chk("reset_err_cnt", 64'(bus.err_cnt), 64'd0);
      chk("reset_timeout", 64'(bus.timeout), 64'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      #1;
      chk("post_reset_ref_ready", 64'(bus.ref_ready), 64'h3F);
      chk("post_reset_dut_ready", 64'(bus.dut_ready), 64'h3F);

      // matching streams on ch0
      push(0, 1, 1, 64'h1122334455667788, 64'h1122334455667788, 8'hFF);
      check_pair(0, 1'b0, "match_ch0");
      chk("match_ch0_err", 64'(cnt_of(0)), 64'd0);

      // masked miscompare on ch0
      push(0, 1, 1, 64'h00000000000000FF, 64'hAB000000000000FF, 8'h01);
      check_pair(0, 1'b0, "mask01_ch0");
      push(0, 1, 1, 64'h00000000000000FF, 64'hAB000000000000FF, 8'h80);
      check_pair(0, 1'b1, "mask80_ch0");
      chk("mask80_err", 64'(cnt_of(0)), 64'd1);
      chk("mask80_total", 64'(bus.total_err), 64'd1);

      // table-driven compares on ch3
      exp_cnt3 = '0;
      for (int i = 0; i < 6; i++) begin
         exp_q.push_back(vecs[i].exp_mis);
         if (vecs[i].exp_mis && exp_cnt3 != 4'hF) exp_cnt3 = exp_cnt3 + 1'b1;
         push(3, 1, 1, vecs[i].ref_d, vecs[i].dut_d, vecs[i].mask);
         check_pair(3, exp_q.pop_front(), $sformatf("vec%0d", i));
         chk($sformatf("vec%0d_err", i), 64'(cnt_of(3)), 64'(exp_cnt3));
      end
      exp_total = TW'(1) + TW'(exp_cnt3);
      chk("table_total", 64'(bus.total_err), 64'(exp_total));

      // skewed latency and backpressure on ch2
      @(posedge clk_i);
      #1;
      bus.ref_mask[2*8 +: 8]   = 8'hFF;
      bus.ref_data[2*DW +: DW] = 64'hA000;
      bus.ref_valid[2]         = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk_i);
         #1;
         bus.ref_data[2*DW +: DW] = 64'hA000 + 64'(i + 1);
         if (i == 6) chk("bp_ready_one_free", 64'(bus.ref_ready[2]), 64'd1);
      end
      chk("bp_ready_full", 64'(bus.ref_ready[2]), 64'd0);
      repeat (2) @(posedge clk_i);
      #1;
      chk("bp_ready_held", 64'(bus.ref_ready[2]), 64'd0);
      bus.ref_valid[2] = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk_i);
         #1;
         bus.dut_data[2*DW +: DW] = 64'hA000 + 64'(i);
         bus.dut_valid[2]         = 1'b1;
         @(posedge clk_i);
         #1;
         bus.dut_valid[2] = 1'b0;
         repeat (2) @(posedge clk_i);
      end
      repeat (3) @(negedge clk_i);
      chk("bp_busy_end", 64'(bus.busy[2]), 64'd0);
      chk("bp_err", 64'(cnt_of(2)), 64'd0);
      chk("bp_timeout", 64'(bus.timeout[2]), 64'd0);
      chk("bp_ready_end", 64'(bus.ref_ready[2]), 64'd1);

      // one-sided wait timeout on ch1
      push(1, 0, 1, 64'h0, 64'h5555AAAA5555AAAA, 8'hFF);
      repeat (15) @(posedge clk_i);
      @(negedge clk_i);
      chk("timeout_15", 64'(bus.timeout[1]), 64'd0);
      @(posedge clk_i);
      @(negedge clk_i);
      chk("timeout_16", 64'(bus.timeout[1]), 64'd1);
      repeat (10) @(negedge clk_i);
      chk("timeout_sticky", 64'(bus.timeout[1]), 64'd1);
      push(1, 1, 0, 64'h5555AAAA5555AAAA, 64'h0, 8'hFF);
      @(negedge clk_i);
      @(negedge clk_i);
      chk("timeout_pair_mismatch", 64'(bus.mismatch[1]), 64'd0);
      chk("timeout_pair_busy", 64'(bus.busy[1]), 64'd0);
      chk("timeout_after_pop", 64'(bus.timeout[1]), 64'd1);

      // saturation on ch4: 20 back-to-back miscomparing pairs
      @(posedge clk_i);
      #1;
      bus.ref_data[4*DW +: DW] = 64'h0;
      bus.dut_data[4*DW +: DW] = 64'h1;
      bus.ref_mask[4*8 +: 8]   = 8'hFF;
      bus.ref_valid[4]         = 1'b1;
      bus.dut_valid[4]         = 1'b1;
      repeat (20) @(posedge clk_i);
      #1;
      idle();
      repeat (4) @(negedge clk_i);
      chk("sat_err", 64'(cnt_of(4)), 64'd15);
      exp_total = exp_total + TW'(15);
      chk("sat_total", 64'(bus.total_err), 64'(exp_total));
      repeat (5) @(negedge clk_i);
      chk("sat_held", 64'(cnt_of(4)), 64'd15);

      // clear with a beat buffered on ch5
      push(5, 1, 0, 64'h77, 64'h0, 8'hFF);
      @(negedge clk_i);
      chk("pre_clear_busy5", 64'(bus.busy[5]), 64'd1);
      @(posedge clk_i);
      #1;
      clear_i = 1'b1;
      #1;
      chk("clear_ref_ready", 64'(bus.ref_ready), 64'd0);
      chk("clear_dut_ready", 64'(bus.dut_ready), 64'd0);
      @(posedge clk_i);
      #1;
      clear_i = 1'b0;
      #1;
      chk("after_clear_ready", 64'(bus.ref_ready), 64'h3F);
      chk("after_clear_err", 64'(bus.err_cnt), 64'd0);
      chk("after_clear_total", 64'(bus.total_err), 64'd0);
      chk("after_clear_timeout", 64'(bus.timeout), 64'd0);
      chk("after_clear_busy", 64'(bus.busy), 64'd0);

      // async reset mid-burst, with a miscompare about to pop on ch3
      push(3, 1, 1, 64'h1, 64'h2, 8'hFF);
      check_pair(3, 1'b1, "pre_reset_ch3");
      @(posedge clk_i);
      #1;
      bus.ref_data[5*DW +: DW] = 64'h99;
      bus.ref_mask[5*8 +: 8]   = 8'hFF;
      bus.ref_valid[5]         = 1'b1;
      repeat (4) @(posedge clk_i);
      #1;
      bus.ref_valid[5]         = 1'b0;
      bus.ref_data[3*DW +: DW] = 64'h10;
      bus.dut_data[3*DW +: DW] = 64'h20;
      bus.ref_mask[3*8 +: 8]   = 8'hFF;
      bus.ref_valid[3]         = 1'b1;
      bus.dut_valid[3]         = 1'b1;
      @(posedge clk_i);
      #1;
      idle();
      chk("pre_reset_busy", 64'(bus.busy), 64'h28);
      #2;
      rst_ni = 1'b0;
      #1;
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_err", 64'(bus.err_cnt), 64'd0);
      chk("rst_total", 64'(bus.total_err), 64'd0);
      chk("rst_mismatch", 64'(bus.mismatch), 64'd0);
      chk("rst_ready", 64'(bus.ref_ready), 64'd0);
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_i);
         chk($sformatf("post_rst_mismatch_%0d", i), 64'(bus.mismatch), 64'd0);
      end
      chk("post_rst_busy", 64'(bus.busy), 64'd0);
      chk("post_rst_ready", 64'(bus.dut_ready), 64'h3F);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
